mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage of the ELC3030 8-bit pipeline. It sits between the execution stage and writeback. It accepts one instruction per handshake from execute and runs data-memory reads and writes over a req/ack bus with a timeout. It owns the stack pointer, updating it on committed PUSH/POP, and presents a registered writeback record to the register file and flag register.

## Interface
Parameters:
- `TIMEOUT`, default 15: max cycles `dmem_req` stays high without `dmem_ack` before abort; legal 2–15.
- `SP_RESET`, default 8'hFF: stack pointer value after reset.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  execute presents an instruction.
- `ex_ready`  out  1  stage can accept; high only in IDLE.
- `ex_addr`  in  8  memory address (SP for push, SP+1 for pop).
- `ex_data`  in  8  ALU result or store data.
- `ex_wb_addr`  in  3  destination register.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write`  in  1 each  operation controls.
- `ex_sp_en`, `ex_sp_op`  in  1 each  stack op; `ex_sp_op` 0 = push, 1 = pop.
- `ex_flags_pop`  in  1  load from memory targets the flags, not a register.
- `dmem_req`  out  1  memory request, held until ack or abort.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  8  memory address.
- `dmem_wdata`  out  8  write data.
- `dmem_rdata`  in  8  read data, valid when `dmem_ack` = 1.
- `dmem_ack`  in  1  single-cycle completion strobe.
- `wb_valid`  out  1  one-cycle writeback strobe.
- `wb_we`  out  1  register-file write enable, qualified by `wb_valid`.
- `wb_addr`  out  3  writeback register.
- `wb_data`  out  8  writeback data.
- `wb_err`  out  1  access aborted by timeout.
- `flags_load`  out  1  flags restore strobe, coincident with `wb_valid`.
- `flags_value`  out  4  restored flags {V,C,N,Z} = `dmem_rdata[3:0]`, registered.
- `sp_out`  out  8  current stack pointer.

## Operation
States:
- **IDLE**: `ex_ready` = 1. An instruction is accepted on an edge where `ex_valid` = 1.
  - If `ex_mem_read` or `ex_mem_write` is set, the stage captures addr/data/controls and goes to REQ.
  - Otherwise it is a pass-through: at that edge, `wb_valid` = 1, `wb_we` = `ex_reg_write`, `wb_data` = `ex_data`, and the stage stays in IDLE.
- **REQ**: `dmem_req` = 1 with `dmem_addr`/`dmem_wdata`/`dmem_we` held stable from the captured values. The stage leaves REQ on ack or on timeout.

On an edge with `dmem_ack` = 1 in REQ (commit), the stage returns to IDLE and registers:
- Read: `wb_data` = `dmem_rdata`.
  - `wb_we` = `ex_reg_write` & ~`ex_flags_pop`.
  - If `ex_flags_pop`: `flags_load` = 1 and `flags_value` = `dmem_rdata[3:0]`.
- Write: `wb_we` = 0 and `wb_data` = store data.
- Stack: if `sp_en`, SP is set to SP-1 for a push or SP+1 for a pop, modulo 256 (0x00 push -> 0xFF; 0xFF pop -> 0x00).

Timeout:
- A 4-bit wait counter clears on REQ entry and increments on each REQ cycle without ack.
- When the counter = `TIMEOUT`-1 with no ack, the stage aborts and returns to IDLE.
- On abort: `wb_valid` = 1, `wb_err` = 1, `wb_we` = 0, `flags_load` = 0, SP unchanged.

Special cases:
- `ex_mem_read` and `ex_mem_write` both set: treated as a write; the read is ignored.
- `dmem_ack` in IDLE is ignored.
- `ex_valid` while not ready is not accepted; execute must hold the instruction.

## Timing
- All outputs are registered except `ex_ready`, which is decoded from state.
- Reset values:
  - state = IDLE, so `ex_ready` = 1.
  - `dmem_req` = 0, `dmem_we` = 0, `dmem_addr` = 0, `dmem_wdata` = 0.
  - `wb_valid`, `wb_we`, `wb_err`, `flags_load` = 0; `wb_addr` = 0, `wb_data` = 0, `flags_value` = 0.
  - `sp_out` = `SP_RESET`.
- Pass-through latency: accept at edge N -> `wb_valid` high for cycle N..N+1 only.
- Memory latency:
  - Accept at edge N; `dmem_req` is high from N.
  - If ack is sampled at edge N+k (k ≥ 1), `wb_valid` and the updated `sp_out` appear after N+k.
  - `ex_ready` returns high in the same cycle that `wb_valid` is high, so back-to-back accepts are allowed.
- `wb_valid`, `flags_load` and `wb_err` are single-cycle pulses; they clear on the next edge unless a new completion occurs.
- Timeout: with no ack, `dmem_req` is high for exactly `TIMEOUT` cycles, then drops at the abort edge.
- Reset mid-REQ: `dmem_req` is low after the reset edge. No writeback, SP = `SP_RESET`. A late ack is ignored.

## Test plan
- Pass-through ADD: `ex_valid` with `ex_reg_write`=1, `ex_data`=0x15, `ex_wb_addr`=2 -> next cycle `wb_valid`=1, `wb_we`=1, `wb_addr`=2, `wb_data`=0x15; `dmem_req` stays 0.
- PUSH:
  - Setup: after reset SP=0xFF; `ex_mem_write`=1, `ex_sp_en`=1, `ex_sp_op`=0, `ex_addr`=0xFF, `ex_data`=0xAA.
  - Stimulus: ack on the 3rd REQ cycle.
  - Expected: `dmem_we`=1 with `dmem_addr`/`dmem_wdata`=0xFF/0xAA held for 3 cycles; then `sp_out`=0xFE, `wb_we`=0.
- POP into R1:
  - Setup: SP=0xFE, `ex_addr`=0xFF, read, `ex_sp_op`=1.
  - Stimulus: immediate ack with `dmem_rdata`=0x5C.
  - Expected: `wb_data`=0x5C, `wb_addr`=1, `wb_we`=1, `sp_out`=0xFF.
- Flags restore: read with `ex_flags_pop`=1, `dmem_rdata`=0xA9 -> `flags_load`=1, `flags_value`=4'h9, `wb_we`=0.
- Timeout: read, never ack, `TIMEOUT`=15 -> `dmem_req` high exactly 15 cycles; `wb_valid`=`wb_err`=1; SP unchanged; `ex_ready` high afterwards.
- Wrap and reset: push at SP=0x00 -> `sp_out`=0xFF. Separately, assert `rst` mid-REQ -> `dmem_req`=0 next cycle, a late ack produces no `wb_valid`, `sp_out`=0xFF.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage: accepts one instruction per handshake from execute,
// runs a req/ack data-memory access with timeout, owns SP, emits a registered writeback record.
module mem_access_unit #(
  parameter int         TIMEOUT  = 15,
  parameter logic [7:0] SP_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  output logic       ex_ready,
  input  logic [7:0] ex_addr,
  input  logic [7:0] ex_data,
  input  logic [2:0] ex_wb_addr,
  input  logic       ex_mem_read,
  input  logic       ex_mem_write,
  input  logic       ex_reg_write,
  input  logic       ex_sp_en,
  input  logic       ex_sp_op,
  input  logic       ex_flags_pop,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [7:0] dmem_addr,
  output logic [7:0] dmem_wdata,
  input  logic [7:0] dmem_rdata,
  input  logic       dmem_ack,
  output logic       wb_valid,
  output logic       wb_we,
  output logic [2:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       wb_err,
  output logic       flags_load,
  output logic [3:0] flags_value,
  output logic [7:0] sp_out
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [3:0] LP_LAST = 4'(TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_wait;
  logic       r_reg_write;
  logic       r_flags_pop;
  logic       r_sp_en;
  logic       r_sp_op;
  logic [2:0] r_wb_addr;
  logic       w_mem_op;

  assign ex_ready = (r_state == S_IDLE);
  assign w_mem_op = ex_mem_read | ex_mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait      <= 4'd0;
      r_reg_write <= 1'b0;
      r_flags_pop <= 1'b0;
      r_sp_en     <= 1'b0;
      r_sp_op     <= 1'b0;
      r_wb_addr   <= 3'd0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 8'd0;
      dmem_wdata  <= 8'd0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_addr     <= 3'd0;
      wb_data     <= 8'd0;
      wb_err      <= 1'b0;
      flags_load  <= 1'b0;
      flags_value <= 4'd0;
      sp_out      <= SP_RESET;
    end else begin
      wb_valid   <= 1'b0;
      wb_err     <= 1'b0;
      flags_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid && w_mem_op) begin
            // A write wins when both read and write are requested.
            r_state     <= S_REQ;
            r_wait      <= 4'd0;
            dmem_req    <= 1'b1;
            dmem_we     <= ex_mem_write;
            dmem_addr   <= ex_addr;
            dmem_wdata  <= ex_data;
            r_reg_write <= ex_reg_write;
            r_flags_pop <= ex_flags_pop;
            r_sp_en     <= ex_sp_en;
            r_sp_op     <= ex_sp_op;
            r_wb_addr   <= ex_wb_addr;
          end else if (ex_valid) begin
            wb_valid <= 1'b1;
            wb_we    <= ex_reg_write;
            wb_addr  <= ex_wb_addr;
            wb_data  <= ex_data;
          end
        end
        S_REQ: begin
          if (dmem_ack) begin
            r_state  <= S_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_addr  <= r_wb_addr;
            if (dmem_we) begin
              wb_we   <= 1'b0;
              wb_data <= dmem_wdata;
            end else begin
              wb_we   <= r_reg_write & ~r_flags_pop;
              wb_data <= dmem_rdata;
              if (r_flags_pop) begin
                flags_load  <= 1'b1;
                flags_value <= dmem_rdata[3:0];
              end
            end
            if (r_sp_en)
              sp_out <= r_sp_op ? sp_out + 8'd1 : sp_out - 8'd1;
          end else if (r_wait == LP_LAST) begin
            r_state  <= S_IDLE;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            wb_we    <= 1'b0;
            wb_addr  <= r_wb_addr;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: pass-through, push/pop,
// flags restore, timeout, SP wrap and reset during an access.
module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid, ex_ready;
  logic [7:0] ex_addr, ex_data;
  logic [2:0] ex_wb_addr;
  logic       ex_mem_read, ex_mem_write, ex_reg_write;
  logic       ex_sp_en, ex_sp_op, ex_flags_pop;
  logic       dmem_req, dmem_we;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic       dmem_ack;
  logic       wb_valid, wb_we, wb_err, flags_load;
  logic [2:0] wb_addr;
  logic [7:0] wb_data, sp_out;
  logic [3:0] flags_value;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(15), .SP_RESET(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_addr(ex_addr), .ex_data(ex_data), .ex_wb_addr(ex_wb_addr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_sp_en(ex_sp_en), .ex_sp_op(ex_sp_op), .ex_flags_pop(ex_flags_pop),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_err(wb_err), .flags_load(flags_load), .flags_value(flags_value),
    .sp_out(sp_out)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Step one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_addr = 0; ex_data = 0; ex_wb_addr = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
    ex_sp_en = 0; ex_sp_op = 0; ex_flags_pop = 0;
  endtask

  // Present one memory instruction; returns after the accept edge.
  task automatic issue(input logic rd, input logic wr, input logic rw, input logic spe,
                       input logic spo, input logic fp, input logic [7:0] a,
                       input logic [7:0] d, input logic [2:0] wa);
    ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_reg_write = rw;
    ex_sp_en = spe; ex_sp_op = spo; ex_flags_pop = fp;
    ex_addr = a; ex_data = d; ex_wb_addr = wa;
    step();
    clr_ex();
  endtask

  task automatic ack_now(input logic [7:0] rd);
    dmem_ack = 1; dmem_rdata = rd;
    step();
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    int cnt;
    clr_ex();
    dmem_ack = 0; dmem_rdata = 0;
    rst = 1;
    step(); step();
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_sp", sp_out, 8'hFF);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_flags", flags_value, 0);
    rst = 0;
    step();

    // Pass-through ADD
    issue(0, 0, 1, 0, 0, 0, 8'h00, 8'h15, 3'd2);
    chk("pt_valid", wb_valid, 1);
    chk("pt_we", wb_we, 1);
    chk("pt_addr", wb_addr, 2);
    chk("pt_data", wb_data, 8'h15);
    chk("pt_req", dmem_req, 0);
    step();
    chk("pt_pulse", wb_valid, 0);

    // PUSH 0xAA at SP=0xFF, ack on the 3rd REQ cycle
    issue(0, 1, 0, 1, 0, 0, 8'hFF, 8'hAA, 3'd0);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("push_req%0d", i), dmem_req, 1);
      chk($sformatf("push_hold%0d", i), {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 8'hFF, 8'hAA});
      chk($sformatf("push_busy%0d", i), ex_ready, 0);
      if (i < 3) step();
    end
    ack_now(8'h00);
    chk("push_valid", wb_valid, 1);
    chk("push_we", wb_we, 0);
    chk("push_data", wb_data, 8'hAA);
    chk("push_sp", sp_out, 8'hFE);
    chk("push_req_off", dmem_req, 0);
    chk("push_ready", ex_ready, 1);

    // POP into R1, immediate ack
    issue(1, 0, 1, 1, 1, 0, 8'hFF, 8'h00, 3'd1);
    ack_now(8'h5C);
    chk("pop_valid", wb_valid, 1);
    chk("pop_data", wb_data, 8'h5C);
    chk("pop_addr", wb_addr, 1);
    chk("pop_we", wb_we, 1);
    chk("pop_sp", sp_out, 8'hFF);
    chk("pop_flags", flags_load, 0);

    // Flags restore
    issue(1, 0, 1, 0, 0, 1, 8'h20, 8'h00, 3'd3);
    ack_now(8'hA9);
    chk("fl_load", flags_load, 1);
    chk("fl_value", flags_value, 4'h9);
    chk("fl_we", wb_we, 0);
    chk("fl_data", wb_data, 8'hA9);
    step();
    chk("fl_pulse", flags_load, 0);
    chk("fl_hold", flags_value, 4'h9);

    // Read and write together behave as a write
    issue(1, 1, 1, 0, 0, 0, 8'h40, 8'h33, 3'd4);
    chk("rw_we", dmem_we, 1);
    ack_now(8'h77);
    chk("rw_data", wb_data, 8'h33);
    chk("rw_wbwe", wb_we, 0);

    // Ack while idle is ignored
    ack_now(8'h11);
    chk("idle_ack", wb_valid, 0);

    // Timeout: never ack, req high for exactly TIMEOUT cycles
    issue(1, 0, 1, 1, 1, 0, 8'h10, 8'h00, 3'd5);
    cnt = 0;
    while (dmem_req && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_cycles", cnt, 15);
    chk("to_valid", wb_valid, 1);
    chk("to_err", wb_err, 1);
    chk("to_we", wb_we, 0);
    chk("to_sp", sp_out, 8'hFF);
    chk("to_ready", ex_ready, 1);
    step();
    chk("to_err_pulse", wb_err, 0);

    // SP wrap: pop at 0xFF -> 0x00, push at 0x00 -> 0xFF
    issue(1, 0, 1, 1, 1, 0, 8'h00, 8'h00, 3'd0);
    ack_now(8'h01);
    chk("wrap_pop", sp_out, 8'h00);
    issue(0, 1, 0, 1, 0, 0, 8'h00, 8'h22, 3'd0);
    ack_now(8'h00);
    chk("wrap_push", sp_out, 8'hFF);

    // Reset mid-REQ after moving SP away from reset value
    issue(0, 1, 0, 1, 0, 0, 8'hFF, 8'h44, 3'd0);
    ack_now(8'h00);
    chk("pre_rst_sp", sp_out, 8'hFE);
    issue(0, 1, 0, 1, 0, 0, 8'hFE, 8'h55, 3'd0);
    chk("mid_req", dmem_req, 1);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_req", dmem_req, 0);
    chk("mrst_ready", ex_ready, 1);
    chk("mrst_sp", sp_out, 8'hFF);
    ack_now(8'h00);
    chk("late_ack_wbv", wb_valid, 0);
    chk("late_ack_sp", sp_out, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
